// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, func codes and the ID->EX bus layout for the execute stage.
package ex_stage_pkg;
  localparam int ID_TO_EX_WD  = 165;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_BUS = 44;
  localparam int StallBus     = 6;
  localparam int DIV_CYCLES   = 32;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;

  // one-hot ALU op bit positions, add in the MSB down to lui in the LSB
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  typedef struct packed {
    logic        signed_div;
    logic [1:0]  hilo_write;
    logic        hilo_we;
    logic [1:0]  hilo_read;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_ZERO, DIV_BUSY, DIV_DONE} div_state_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction
endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring radix-2 divider; holds its result in DONE until ack so one
// instruction never launches twice.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  div_state_t  state, next;
  logic [31:0] rem, quo, dsr;
  logic [5:0]  cnt;
  logic        neg_q, neg_r;
  logic [32:0] trial, diff;
  logic        fits;

  assign trial = {rem, quo[31]};
  assign diff  = trial - {1'b0, dsr};
  assign fits  = trial >= {1'b0, dsr};

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= DIV_IDLE;
    else     state <= next;

  always_comb begin
    next = state;
    case (state)
      DIV_IDLE: if (start) next = (divisor == 32'd0) ? DIV_ZERO : DIV_BUSY;
      DIV_ZERO: next = DIV_DONE;
      DIV_BUSY: if (cnt == 6'(DIV_CYCLES - 1)) next = DIV_DONE;
      DIV_DONE: if (ack) next = DIV_IDLE;
      default:  next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0; quo <= '0; dsr <= '0; cnt <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          rem   <= '0;
          quo   <= neg_if(dividend, is_signed & dividend[31]);
          dsr   <= neg_if(divisor, is_signed & divisor[31]);
          cnt   <= '0;
          neg_q <= is_signed & (dividend[31] ^ divisor[31]);
          neg_r <= is_signed & dividend[31];
        end
        DIV_ZERO: begin
          rem <= '0; quo <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
        end
        DIV_BUSY: begin
          rem <= fits ? diff[31:0] : trial[31:0];
          quo <= {quo[30:0], fits};
          cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == DIV_IDLE && start) || state == DIV_ZERO || state == DIV_BUSY;
  assign done      = state == DIV_DONE;
  assign quotient  = neg_if(quo, neg_q);
  assign remainder = neg_if(rem, neg_r);
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, HI/LO, divider, data-SRAM request.
// Define EX_MULT_EN to enable single-cycle mult/multu into HI/LO.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_BUS-1:0] ex_to_rf_bus,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);
  id_ex_t      ex;
  logic [31:0] hi, lo, src1, src2, alu_res, result, imm_sx, imm_zx, quotient, remainder;
  logic [5:0]  func;
  logic        special, div_present, div_done, ack, ex_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   ex <= '0;
    else if (stall[2] == Stop && stall[3] == NoStop) ex <= '0;
    else if (stall[2] == NoStop)               ex <= id_ex_t'(id_to_ex_bus);
  end

  assign func        = ex.inst[5:0];
  assign special     = ex.inst[31:26] == 6'd0;
  assign div_present = special && (func == FUNC_DIV || func == FUNC_DIVU);
  assign ack         = stall[2] == NoStop;
  assign ex_adv      = stall[3] == NoStop;
  assign imm_sx      = {{16{ex.inst[15]}}, ex.inst[15:0]};
  assign imm_zx      = {16'd0, ex.inst[15:0]};

  assign src1 = ({32{ex.sel_src1[0]}} & ex.rdata1) | ({32{ex.sel_src1[1]}} & ex.pc)
              | ({32{ex.sel_src1[2]}} & {27'd0, ex.inst[10:6]});
  assign src2 = ({32{ex.sel_src2[0]}} & ex.rdata2) | ({32{ex.sel_src2[1]}} & imm_sx)
              | ({32{ex.sel_src2[2]}} & 32'h8) | ({32{ex.sel_src2[3]}} & imm_zx);

  always_comb begin
    alu_res = '0;
    if (ex.alu_op[ALU_ADD])  alu_res |= src1 + src2;
    if (ex.alu_op[ALU_SUB])  alu_res |= src1 - src2;
    if (ex.alu_op[ALU_SLT])  alu_res |= {31'd0, $signed(src1) < $signed(src2)};
    if (ex.alu_op[ALU_SLTU]) alu_res |= {31'd0, src1 < src2};
    if (ex.alu_op[ALU_AND])  alu_res |= src1 & src2;
    if (ex.alu_op[ALU_NOR])  alu_res |= ~(src1 | src2);
    if (ex.alu_op[ALU_OR])   alu_res |= src1 | src2;
    if (ex.alu_op[ALU_XOR])  alu_res |= src1 ^ src2;
    if (ex.alu_op[ALU_SLL])  alu_res |= src2 << src1[4:0];
    if (ex.alu_op[ALU_SRL])  alu_res |= src2 >> src1[4:0];
    if (ex.alu_op[ALU_SRA])  alu_res |= 32'($signed(src2) >>> src1[4:0]);
    if (ex.alu_op[ALU_LUI])  alu_res |= {src2[15:0], 16'd0};
  end

  div_iter u_div (
    .clk(clk), .rst(rst), .start(div_present), .is_signed(ex.signed_div),
    .dividend(ex.rdata1), .divisor(ex.rdata2), .ack(ack),
    .busy(stallreq_for_ex), .done(div_done), .quotient(quotient), .remainder(remainder)
  );

`ifdef EX_MULT_EN
  logic        mult_present, mult_signed;
  logic [63:0] mul_a, mul_b, product;
  assign mult_present = special && (func == FUNC_MULT || func == FUNC_MULTU);
  assign mult_signed  = func == FUNC_MULT;
  assign mul_a        = {{32{mult_signed & ex.rdata1[31]}}, ex.rdata1};
  assign mul_b        = {{32{mult_signed & ex.rdata2[31]}}, ex.rdata2};
  assign product      = mul_a * mul_b;
`endif

  // HI/LO commit on the edge the instruction leaves EX, so a following mfhi/mflo sees it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0; lo <= '0;
    end else if (div_done && ack) begin
      hi <= remainder; lo <= quotient;
    end else if (ex_adv) begin
      if (ex.hilo_we && ex.hilo_write[1]) hi <= ex.rdata1;
      if (ex.hilo_we && ex.hilo_write[0]) lo <= ex.rdata1;
`ifdef EX_MULT_EN
      if (mult_present) begin
        hi <= product[63:32]; lo <= product[31:0];
      end
`endif
    end
  end

  assign result = ex.hilo_read[1] ? hi : ex.hilo_read[0] ? lo : alu_res;

  assign ex_to_mem_bus   = {ex.pc, ex.ram_en, ex.ram_wen, ex.sel_rf_res, ex.rf_we, ex.rf_waddr, result};
  assign ex_to_rf_bus    = {ex.inst[31:26], ex.rf_we, ex.rf_waddr, result};
  assign data_sram_en    = ex.ram_en;
  assign data_sram_wen   = stallreq_for_ex ? 4'd0 : ex.ram_wen;
  assign data_sram_addr  = result;
  assign data_sram_wdata = ex.rdata2;

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], ex.inst[25:16]};
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Registers id_to_ex_bus and computes the ALU result.
- Owns the HI/LO registers and runs an iterative radix-2 divider for div/divu.
- Issues the data-SRAM request, drives the EX forwarding bus back to ID, and passes results to MEM through ex_to_mem_bus.

Parameters:
ID_TO_EX_WD, 165, width of incoming ID->EX bus (bits 164:0)
EX_TO_MEM_WD, 76, width of EX->MEM bus
EX_TO_RF_BUS, 44, width of EX forwarding bus {op[5:0], we, waddr[4:0], wdata[31:0]}
DIV_CYCLES, 32, divider iteration count

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
stall  input  6  StallBus; stall[2] = ID/EX register hold, stall[3] = EX/MEM hold
id_to_ex_bus  input  165  {signed_div, hilo_write[1:0], hilo_we, hilo_read[1:0], pc, inst, alu_op[11:0], sel_src1[2:0], sel_src2[3:0], ram_en, ram_wen[3:0], rf_we, rf_waddr, sel_rf_res, rdata1, rdata2}
ex_to_mem_bus  output  76  {pc, ram_en, ram_wen[3:0], sel_rf_res, rf_we, rf_waddr, result}
ex_to_rf_bus  output  44  {inst[31:26], rf_we, rf_waddr, result} for ID forwarding/load-use detection
stallreq_for_ex  output  1  divider busy; stall controller freezes stages 0..3
data_sram_en  output  1  data RAM enable
data_sram_wen  output  4  byte write enable
data_sram_addr  output  32  ALU result
data_sram_wdata  output  32  rdata2

Behaviour:
- Stage register, updated on posedge clk:
  - stall[2]=Stop and stall[3]=NoStop -> load all-zero bubble.
  - stall[2]=NoStop -> load id_to_ex_bus.
  - Otherwise -> hold.
  - Reset clears it to zero.
- Operand select is one-hot:
  - src1: [0] rdata1, [1] pc, [2] {27'b0, inst[10:6]}.
  - src2: [0] rdata2, [1] sign-extended inst[15:0], [2] 32'h8, [3] zero-extended inst[15:0].
- ALU ops are one-hot add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui:
  - Shifts use src1[4:0] as the amount and src2 as the data; sra is arithmetic.
  - slt is signed and sltu unsigned; both give a 0/1 result.
  - lui gives {src2[15:0], 16'b0}.
  - add/sub wrap mod 2^32.
- Result mux: hilo_read[1] (mfhi) -> HI; hilo_read[0] (mflo) -> LO; otherwise ALU result.
- All outputs are combinational from the stage register plus HI/LO, so a bubble drives zeros.
- HI/LO registers:
  - Reset value 0.
  - mthi: HI<=rdata1. mtlo: LO<=rdata1. Write happens at posedge while the instruction sits in EX and the stage is not stalled.
  - mfhi/mflo read the current value; an mthi immediately followed by mfhi sees the new value because HI/LO update at the EX exit edge.
- Divider FSM, states IDLE, ZERO, BUSY, DONE:
  - IDLE:
    - div/divu in stage with rdata2==0 -> ZERO.
    - div/divu in stage with rdata2!=0 -> BUSY, loading |dividend|, |divisor| (or raw values for divu) and count=0.
  - ZERO: one cycle, quotient=0 and remainder=0 -> DONE.
  - BUSY: one restoring shift-subtract step per cycle; count==DIV_CYCLES-1 -> DONE.
  - DONE:
    - Write LO=quotient and HI=remainder once, with sign fix-up for div: quotient negated if signs differ, remainder takes the dividend's sign.
    - Stay in DONE until stall[2]==NoStop, then -> IDLE, so the same instruction never relaunches.
  - stallreq_for_ex=1 in IDLE-with-div-present, ZERO, and BUSY; 0 in DONE and otherwise.
  - Latency: div enters EX at cycle 0; stallreq deasserts at cycle 33 (cycle 2 for divide-by-zero).
- Memory: data_sram_en=ram_en; data_sram_wen=ram_wen, forced to 0 while stallreq_for_ex=1.
- Reset mid-division: FSM -> IDLE, HI/LO/stage register -> 0, stallreq -> 0.
- Bubble or non-div instruction: FSM stays IDLE.

Optional Feature:
- EX_MULT_EN defined: mult/multu (func 011000/011001) compute a signed/unsigned 64-bit product in one cycle; HI=[63:32], LO=[31:0].
- Undefined: mult/multu leave HI/LO unchanged and behave as nops.

Decomposition:
- Shared defines header holds:
  - bus width macros ID_TO_EX_WD, EX_TO_MEM_WD, EX_TO_RF_BUS, StallBus;
  - Stop/NoStop;
  - func codes DIV/DIVU/MULT/MULTU.
- Sub-module div_iter: the divider FSM with ports start, signed, dividend, divisor, busy, done, quotient, remainder, and an ack input.

Test Plan:
- addu rdata1=5, rdata2=0xFFFFFFFF -> result 4; ex_to_rf_bus we=1 with correct waddr.
- lui, imm 0x1234 -> result 0x12340000; sra rt=0x80000000, sa=4 -> 0xF8000000.
- div -7/2 -> stallreq high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
- div by zero -> stallreq high 2 cycles, then HI=LO=0; no relaunch while stall[2] is held 3 extra cycles.
- stall[2]=Stop, stall[3]=NoStop with sw in flight -> next cycle data_sram_en=0, wen=0, rf_we=0 (bubble).
- rst asserted at BUSY cycle 10 -> immediately stallreq=0, HI=LO=0; subsequent mthi 0xA then mfhi -> result 0xA.
